// File: rtl/move_applier_if.sv
// rtl/move_applier_if.sv - move packet in, authoritative board state out
//
// Bundles the move-selection handshake (sys_state, moved, move_packet) with
// the board/game status returned by move_applier.
//   master : move selection / link RX side (drives packet, observes board)
//   slave  : move_applier (observes packet, drives board and status)
// stable_board is [row][col], 4-bit piece code per square.
interface move_applier_if;
    logic [1:0]             sys_state;
    logic                   moved;
    logic [11:0]            move_packet;
    logic [7:0][7:0][3:0]   stable_board;
    logic                   curr_player;
    logic                   applied;
    logic                   rejected;
    logic [3:0]             captured;
    logic                   game_over;
    logic [7:0]             move_count;

    modport master (
        output sys_state, moved, move_packet,
        input  stable_board, curr_player, applied, rejected,
               captured, game_over, move_count
    );

    modport slave (
        input  sys_state, moved, move_packet,
        output stable_board, curr_player, applied, rejected,
               captured, game_over, move_count
    );
endinterface

// File: rtl/move_applier.sv
// rtl/move_applier.sv - validates and applies move packets to the 8x8 board
//
// Ports:
//   CLOCK_50  in   system clock
//   reset_n   in   asynchronous active-low reset
//   bus       slave modport of move_applier_if:
//     sys_state    in   moves accepted only when equal to CHESS_SCREEN
//     moved        in   packet-valid level, held >= MIN_HOLD cycles
//     move_packet  in   {src_row,src_col,dst_row,dst_col}, 3 bits each
//     stable_board out  authoritative board [row][col]
//     curr_player  out  side to move (1 = codes 0-5, 0 = codes 6-11)
//     applied      out  1-cycle pulse, move committed
//     rejected     out  1-cycle pulse, move refused
//     captured     out  code taken by last applied move (EMPTY if none)
//     game_over    out  sticky, a king was captured
//     move_count   out  applied moves, saturating at 255
module move_applier #(
    parameter logic [3:0] EMPTY        = 4'd15,
    parameter int         MIN_HOLD     = 2,
    parameter logic [1:0] CHESS_SCREEN = 2'd1
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    move_applier_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_QUAL     = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_COMMIT   = 3'd3;
    localparam logic [2:0] S_REJECT   = 3'd4;
    localparam logic [2:0] S_WAIT_LOW = 3'd5;

    // Entry into QUAL already accounts for one high cycle, so the packet is
    // latched once the counter reaches MIN_HOLD-1 with moved still high.
    localparam logic [7:0] HOLD_LAST = 8'(MIN_HOLD - 1);

    logic [2:0]           r_state;
    logic [7:0]           r_hold_cnt;
    logic [11:0]          r_pkt;
    logic [3:0]           r_src_code;
    logic [3:0]           r_dst_code;
    logic [7:0][7:0][3:0] r_board;
    logic                 r_player;
    logic                 r_applied;
    logic                 r_rejected;
    logic [3:0]           r_captured;
    logic                 r_game_over;
    logic [7:0]           r_count;

    logic [2:0] w_sr, w_sc, w_dr, w_dc;
    logic [3:0] w_src, w_dst, w_new_code;
    logic       w_chess, w_same_sq, w_reject, w_king_hit;

    function automatic logic [3:0] back_rank(input int col);
        case (col)
            0, 7:    back_rank = 4'd0;
            1, 6:    back_rank = 4'd1;
            2, 5:    back_rank = 4'd2;
            3:       back_rank = 4'd3;
            default: back_rank = 4'd4;
        endcase
    endfunction

    function automatic logic [7:0][7:0][3:0] initial_board();
        logic [7:0][7:0][3:0] b;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b[r][c] = EMPTY;
            end
        end
        for (int c = 0; c < 8; c++) begin
            b[0][c] = back_rank(c) + 4'd6;
            b[1][c] = 4'd11;
            b[6][c] = 4'd5;
            b[7][c] = back_rank(c);
        end
        return b;
    endfunction

    // Codes 12-14 carry no owner, same as EMPTY.
    function automatic logic owned_by(input logic [3:0] code, input logic player);
        owned_by = (code < 4'd12) && ((code < 4'd6) == player);
    endfunction

    assign w_sr = r_pkt[11:9];
    assign w_sc = r_pkt[8:6];
    assign w_dr = r_pkt[5:3];
    assign w_dc = r_pkt[2:0];

    assign w_chess   = (bus.sys_state == CHESS_SCREEN);
    assign w_src     = r_board[w_sr][w_sc];
    assign w_dst     = r_board[w_dr][w_dc];
    assign w_same_sq = (r_pkt[11:6] == r_pkt[5:0]);
    // An unowned src (empty or opponent) fails the first term.
    assign w_reject  = !owned_by(w_src, r_player) || w_same_sq
                       || owned_by(w_dst, r_player);

    always_comb begin
        w_new_code = r_src_code;
        if (r_src_code == 4'd5 && w_dr == 3'd0) begin
            w_new_code = 4'd3;
        end else if (r_src_code == 4'd11 && w_dr == 3'd7) begin
            w_new_code = 4'd9;
        end
    end

    assign w_king_hit = (r_dst_code == 4'd4) || (r_dst_code == 4'd10);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= 8'd0;
            r_pkt       <= 12'd0;
            r_src_code  <= EMPTY;
            r_dst_code  <= EMPTY;
            r_board     <= initial_board();
            r_player    <= 1'b1;
            r_applied   <= 1'b0;
            r_rejected  <= 1'b0;
            r_captured  <= EMPTY;
            r_game_over <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            r_applied  <= 1'b0;
            r_rejected <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.moved && w_chess && !r_game_over) begin
                        r_state    <= S_QUAL;
                        r_hold_cnt <= 8'd1;
                    end
                end
                S_QUAL: begin
                    if (!bus.moved || !w_chess) begin
                        r_state <= S_IDLE;
                    end else if (r_hold_cnt >= HOLD_LAST) begin
                        r_pkt   <= bus.move_packet;
                        r_state <= S_CHECK;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (!w_chess) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_src_code <= w_src;
                        r_dst_code <= w_dst;
                        r_state    <= w_reject ? S_REJECT : S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // src and dst differ here, so the two writes never collide.
                    r_board[w_sr][w_sc] <= EMPTY;
                    r_board[w_dr][w_dc] <= w_new_code;
                    r_captured <= (r_dst_code < 4'd12) ? r_dst_code : EMPTY;
                    if (w_king_hit) begin
                        r_game_over <= 1'b1;
                    end
                    r_player  <= ~r_player;
                    if (r_count != 8'hFF) begin
                        r_count <= r_count + 8'd1;
                    end
                    r_applied <= 1'b1;
                    r_state   <= S_WAIT_LOW;
                end
                S_REJECT: begin
                    r_rejected <= 1'b1;
                    r_state    <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // One application per packet, however long it is held.
                    if (!bus.moved) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stable_board = r_board;
    assign bus.curr_player  = r_player;
    assign bus.applied      = r_applied;
    assign bus.rejected     = r_rejected;
    assign bus.captured     = r_captured;
    assign bus.game_over    = r_game_over;
    assign bus.move_count   = r_count;

endmodule

// File: tb/tb_move_applier.sv
// tb/tb_move_applier.sv - self-checking bench for move_applier
module tb_move_applier;

    localparam logic [1:0] CHESS = 2'd1;
    localparam logic [1:0] MENU  = 2'd0;

    logic clk;
    logic rst_n;

    move_applier_if bus ();

    move_applier #(
        .EMPTY        (4'd15),
        .MIN_HOLD     (2),
        .CHESS_SCREEN (CHESS)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model of the game state
    int mb [8][8];
    int m_player, m_count, m_cap;
    bit m_go;
    bit e_app, e_rej;
    bit cmp_en = 1'b0;

    int last_pulses, last_pcyc, last_out;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int owner(input int code);
        if (code <= 5) return 1;
        if (code <= 11) return 0;
        return -1;
    endfunction

    function automatic void model_init();
        int br [8];
        br = '{0, 1, 2, 3, 4, 2, 1, 0};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[r][c] = 15;
        for (int c = 0; c < 8; c++) begin
            mb[0][c] = br[c] + 6;
            mb[1][c] = 11;
            mb[6][c] = 5;
            mb[7][c] = br[c];
        end
        m_player = 1;
        m_count  = 0;
        m_cap    = 15;
        m_go     = 1'b0;
        e_app    = 1'b0;
        e_rej    = 1'b0;
    endfunction

    // 1 = legal, 2 = refused
    function automatic int eval(input logic [11:0] p);
        int sr, sc, dr, dc, s, d;
        sr = int'(p[11:9]); sc = int'(p[8:6]); dr = int'(p[5:3]); dc = int'(p[2:0]);
        s = mb[sr][sc];
        d = mb[dr][dc];
        if (owner(s) != m_player) return 2;
        if (sr == dr && sc == dc) return 2;
        if (owner(d) == m_player) return 2;
        return 1;
    endfunction

    function automatic void apply_model(input logic [11:0] p);
        int sr, sc, dr, dc, s, d, v;
        sr = int'(p[11:9]); sc = int'(p[8:6]); dr = int'(p[5:3]); dc = int'(p[2:0]);
        s = mb[sr][sc];
        d = mb[dr][dc];
        v = s;
        if (s == 5 && dr == 0) v = 3;
        if (s == 11 && dr == 7) v = 9;
        mb[sr][sc] = 15;
        mb[dr][dc] = v;
        m_cap = (owner(d) < 0) ? 15 : d;
        if (d == 4 || d == 10) m_go = 1'b1;
        m_player = 1 - m_player;
        if (m_count < 255) m_count++;
    endfunction

    function automatic logic [11:0] pk(input int sr, input int sc, input int dr, input int dc);
        return {3'(sr), 3'(sc), 3'(dr), 3'(dc)};
    endfunction

    function automatic int sq(input int r, input int c);
        return int'(bus.stable_board[r][c]);
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            int bad;
            bad = 0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (sq(r, c) != mb[r][c]) bad++;
            chk("board_diff_squares", bad, 0);
            chk("curr_player", int'(bus.curr_player), m_player);
            chk("move_count", int'(bus.move_count), m_count);
            chk("captured", int'(bus.captured), m_cap);
            chk("game_over", int'(bus.game_over), int'(m_go));
            chk("applied", int'(bus.applied), int'(e_app));
            chk("rejected", int'(bus.rejected), int'(e_rej));
        end
    end

    // mode: 0 normal, 1 sys_state never CHESS, 2 sys_state drops after first edge
    task automatic send(input logic [11:0] pkt, input int hold, input int mode, input int rst_at);
        int out, npulse, pcyc;
        out = (mode != 0 || hold < 2 || m_go) ? 0 : eval(pkt);
        npulse = 0;
        pcyc   = -1;
        @(posedge clk); #1;
        bus.sys_state   = (mode == 1) ? MENU : CHESS;
        bus.moved       = 1'b1;
        bus.move_packet = pkt;
        for (int cyc = 1; cyc <= hold + 6; cyc++) begin
            @(posedge clk); #1;
            if (bus.applied || bus.rejected) begin
                npulse++;
                pcyc = cyc;
            end
            if (cyc == 1 && mode == 2) bus.sys_state = MENU;
            if (cyc == 2) bus.move_packet = ~pkt;
            if (cyc == hold) bus.moved = 1'b0;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                model_init();
                out = 0;
                bus.moved = 1'b0;
            end
            if (cyc == rst_at + 1) rst_n = 1'b1;
            if (cyc == 4) begin
                e_app = (out == 1);
                e_rej = (out == 2);
                if (out == 1) apply_model(pkt);
            end
            if (cyc == 5) begin
                e_app = 1'b0;
                e_rej = 1'b0;
            end
        end
        bus.sys_state = CHESS;
        last_pulses = npulse;
        last_pcyc   = pcyc;
        last_out    = out;
        chk("pulse_count", npulse, (out != 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.sys_state   = CHESS;
        bus.moved       = 1'b0;
        bus.move_packet = 12'd0;
        model_init();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset state, pinned by hand
        @(negedge clk);
        chk("reset_sq_0_4", sq(0, 4), 10);
        chk("reset_sq_0_0", sq(0, 0), 6);
        chk("reset_sq_1_5", sq(1, 5), 11);
        chk("reset_sq_3_3", sq(3, 3), 15);
        chk("reset_sq_6_2", sq(6, 2), 5);
        chk("reset_sq_7_3", sq(7, 3), 3);
        chk("reset_player", int'(bus.curr_player), 1);
        chk("reset_count", int'(bus.move_count), 0);
        chk("reset_captured", int'(bus.captured), 15);

        // White pawn advance, held 8 cycles
        send(pk(6, 4, 4, 4), 8, 0, -1);
        chk("first_apply_latency", last_pcyc, 4);
        chk("first_apply_pulses", last_pulses, 1);
        chk("first_sq_6_4", sq(6, 4), 15);
        chk("first_sq_4_4", sq(4, 4), 5);
        chk("first_player", int'(bus.curr_player), 0);
        chk("first_count", int'(bus.move_count), 1);

        // Glitch, empty source, wrong colour, same square, own target, screen gating
        send(pk(1, 3, 3, 3), 1, 0, -1);
        chk("glitch_no_pulse", last_pulses, 0);
        send(pk(3, 3, 4, 4), 8, 0, -1);
        chk("empty_src_outcome", last_out, 2);
        send(pk(1, 0, 2, 0), 8, 0, -1);
        chk("black_sq_2_0", sq(2, 0), 11);
        send(pk(1, 1, 2, 1), 8, 0, -1);
        chk("wrong_colour_outcome", last_out, 2);
        send(pk(6, 0, 6, 0), 4, 0, -1);
        send(pk(7, 1, 6, 1), 4, 0, -1);
        chk("own_target_outcome", last_out, 2);
        send(pk(6, 1, 5, 1), 4, 1, -1);
        send(pk(6, 1, 5, 1), 4, 2, -1);
        chk("screen_drop_sq_6_1", sq(6, 1), 5);

        // Capture of black knight
        send(pk(7, 1, 0, 1), 4, 0, -1);
        chk("capture_code", int'(bus.captured), 7);
        send(pk(1, 7, 2, 7), 4, 0, -1);

        // Promotions
        send(pk(6, 0, 0, 0), 4, 0, -1);
        chk("promo_white", sq(0, 0), 3);
        chk("promo_white_captured", int'(bus.captured), 6);
        send(pk(1, 6, 7, 6), 4, 0, -1);
        chk("promo_black", sq(7, 6), 9);

        // King capture locks the game
        send(pk(0, 1, 0, 4), 4, 0, -1);
        chk("king_game_over", int'(bus.game_over), 1);
        chk("king_captured", int'(bus.captured), 10);
        send(pk(1, 5, 2, 5), 8, 0, -1);
        chk("after_go_sq_1_5", sq(1, 5), 11);
        chk("after_go_pulses", last_pulses, 0);

        // Reset during COMMIT restores the initial board
        do_reset();
        send(pk(6, 4, 4, 4), 3, 0, 3);
        chk("midreset_sq_6_4", sq(6, 4), 5);
        chk("midreset_sq_4_4", sq(4, 4), 15);
        chk("midreset_count", int'(bus.move_count), 0);
        chk("midreset_player", int'(bus.curr_player), 1);

        // Knight shuffle to saturate move_count
        for (int i = 0; i < 65; i++) begin
            send(pk(7, 1, 5, 2), 2, 0, -1);
            send(pk(0, 1, 2, 2), 2, 0, -1);
            send(pk(5, 2, 7, 1), 2, 0, -1);
            send(pk(2, 2, 0, 1), 2, 0, -1);
        end
        chk("count_saturated", int'(bus.move_count), 255);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
